// File: rtl/universal_shift_reg_if.sv
// Bundles the operation request, data and status signals of universal_shift_reg.
//   enable, mode, amt, D, sin : operation request driven by the master
//   Q, sout, busy, done, parity: register contents and status driven by the slave
// Modports: master (requester), slave (shift register).
interface universal_shift_reg_if #(
    parameter int unsigned WIDTH = 8
) ();
    localparam int unsigned AW = $clog2(WIDTH + 1);

    logic             enable;
    logic [2:0]       mode;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] D;
    logic             sin;
    logic [WIDTH-1:0] Q;
    logic             sout;
    logic             busy;
    logic             done;
    logic             parity;

    modport master (
        output enable, mode, amt, D, sin,
        input  Q, sout, busy, done, parity
    );

    modport slave (
        input  enable, mode, amt, D, sin,
        output Q, sout, busy, done, parity
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold/load/clear complete in one edge; shift,
// rotate and arithmetic-shift opcodes run one bit step per edge for amt steps.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; returns Q to INIT and aborts any operation
//   bus   : universal_shift_reg_if.slave (enable, mode, amt, D, sin in;
//           Q, sout, busy, done, parity out)
// Optional feature: define PARITY_EN to register even parity of Q; otherwise
// parity is tied to 0.
module universal_shift_reg #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    universal_shift_reg_if.slave bus
);
    localparam int unsigned AW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_ROTL  = 3'b100;
    localparam logic [2:0] OP_ROTR  = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        STEP = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] q, q_n;
    logic             sout_r, sout_n;
    logic             done_r, done_n;
    logic [2:0]       op, op_n;
    logic [AW-1:0]    cnt, cnt_n;

    // One bit step: returns {ejected bit, new contents}; non-shift ops pass through.
    function automatic logic [WIDTH:0] step_fn(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] v,
        input logic             s,
        input logic             o
    );
        logic [WIDTH:0] r;
        case (m)
            OP_SHL:  r = {v[WIDTH-1], v[WIDTH-2:0], s};
            OP_SHR:  r = {v[0], s, v[WIDTH-1:1]};
            OP_ROTL: r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROTR: r = {v[0], v[0], v[WIDTH-1:1]};
            OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: r = {o, v};
        endcase
        return r;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            q      <= INIT;
            sout_r <= 1'b0;
            done_r <= 1'b0;
            op     <= OP_HOLD;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            q      <= q_n;
            sout_r <= sout_n;
            done_r <= done_n;
            op     <= op_n;
            cnt    <= cnt_n;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_n = state;
        q_n     = q;
        sout_n  = sout_r;
        done_n  = 1'b0;
        op_n    = op;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (bus.enable) begin
                    case (bus.mode)
                        OP_HOLD:  done_n = 1'b1;
                        OP_LOAD: begin
                            q_n    = bus.D;
                            done_n = 1'b1;
                        end
                        OP_CLEAR: begin
                            q_n    = '0;
                            done_n = 1'b1;
                        end
                        default: begin
                            if (bus.amt == '0) begin
                                done_n = 1'b1;
                            end else begin
                                // First step happens on the accepting edge.
                                {sout_n, q_n} = step_fn(bus.mode, q, bus.sin, sout_r);
                                if (bus.amt == AW'(1)) begin
                                    done_n = 1'b1;
                                end else begin
                                    state_n = STEP;
                                    op_n    = bus.mode;
                                    cnt_n   = bus.amt - AW'(1);
                                end
                            end
                        end
                    endcase
                end
            end
            STEP: begin
                // cnt holds the steps still to run, including this one.
                {sout_n, q_n} = step_fn(op, q, bus.sin, sout_r);
                cnt_n         = cnt - AW'(1);
                if (cnt == AW'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef PARITY_EN
    logic parity_r;

    // Even parity tracks the value being written into Q on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_r <= ^INIT;
        end else begin
            parity_r <= ^q_n;
        end
    end

    assign bus.parity = parity_r;
`else
    assign bus.parity = 1'b0;
`endif

    assign bus.Q    = q;
    assign bus.sout = sout_r;
    assign bus.busy = (state == STEP);
    assign bus.done = done_r;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8, INIT=8'hA5): directed
// scenarios with literal expectations followed by randomized operations, all
// checked every cycle against a behavioural model.
module tb_universal_shift_reg;
    localparam int unsigned W  = 8;
    localparam int unsigned AW = $clog2(W + 1);
    localparam logic [W-1:0] INIT_V = 8'hA5;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   started  = 1'b0;

    universal_shift_reg_if #(.WIDTH(W)) bus ();

    universal_shift_reg #(.WIDTH(W), .INIT(INIT_V)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: Q as a number, remaining step count, latched opcode.
    logic [W-1:0] mq;
    logic         ms;
    logic         md;
    int           rem;
    int           mop;

    function automatic logic [W:0] mstep(input int op, input logic [W-1:0] v, input logic s);
        logic [W-1:0] n;
        logic         o;
        case (op)
            2: begin n = W'((v * 2) % 256) | W'(s);            o = v[W-1]; end
            3: begin n = (v / 2) | W'(s ? 8'h80 : 8'h00);     o = v[0];   end
            4: begin n = W'((v * 2) % 256) | W'(v / 128);     o = v[W-1]; end
            5: begin n = (v / 2) | W'((v % 2) * 128);         o = v[0];   end
            default: begin n = W'($signed(v) >>> 1);          o = v[0];   end
        endcase
        return {o, n};
    endfunction

    always @(posedge clk) begin
        started <= 1'b1;
        if (reset) begin
            mq = INIT_V; ms = 1'b0; md = 1'b0; rem = 0;
        end else if (rem > 0) begin
            {ms, mq} = mstep(mop, mq, bus.sin);
            rem--;
            md = (rem == 0);
        end else if (bus.enable) begin
            md = 1'b1;
            case (int'(bus.mode))
                0: ;
                1: mq = bus.D;
                7: mq = '0;
                default: begin
                    if (bus.amt != 0) begin
                        {ms, mq} = mstep(int'(bus.mode), mq, bus.sin);
                        mop = int'(bus.mode);
                        rem = int'(bus.amt) - 1;
                        md  = (rem == 0);
                    end
                end
            endcase
        end else begin
            md = 1'b0;
        end
    end

    // Compare process: every cycle once the first edge has seeded the model.
    always @(negedge clk) begin
        if (started) begin
            check("Q", 64'(bus.Q), 64'(mq));
            check("sout", 64'(bus.sout), 64'(ms));
            check("busy", 64'(bus.busy), 64'(rem > 0));
            check("done", 64'(bus.done), 64'(md));
`ifdef PARITY_EN
            check("parity", 64'(bus.parity), 64'(^mq));
`else
            check("parity", 64'(bus.parity), 64'(0));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic en, input int m, input int a, input logic [W-1:0] d, input logic s);
        bus.enable = en;
        bus.mode   = 3'(m);
        bus.amt    = AW'(a);
        bus.D      = d;
        bus.sin    = s;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (bus.done !== 1'b1 && k < budget) begin
            cyc();
            k++;
        end
        check("wait_done", 64'(bus.done), 64'(1));
    endtask

    initial begin
        reset = 1'b1;
        req(1'b0, 0, 0, '0, 1'b0);
        cyc(); cyc();
        check("rst_Q", 64'(bus.Q), 64'h A5);
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_sout", 64'(bus.sout), 64'(0));
        reset = 1'b0;

        // load 81, then shl by 3 with sin=1; mode/enable changes while busy ignored
        req(1'b1, 1, 0, 8'h81, 1'b0); cyc();
        check("load_Q", 64'(bus.Q), 64'h81);
        check("load_done", 64'(bus.done), 64'(1));
        req(1'b1, 2, 3, 8'h00, 1'b1); cyc();
        check("shl_busy1", 64'(bus.busy), 64'(1));
        req(1'b1, 7, 0, 8'h00, 1'b1); cyc();
        check("shl_busy2", 64'(bus.busy), 64'(1));
        check("shl_done_early", 64'(bus.done), 64'(0));
        req(1'b0, 0, 0, 8'h00, 1'b1); cyc();
        check("shl_Q", 64'(bus.Q), 64'h0F);
        check("shl_sout", 64'(bus.sout), 64'(0));
        check("shl_done", 64'(bus.done), 64'(1));
        check("shl_busy_end", 64'(bus.busy), 64'(0));
        cyc();
        check("shl_single_done", 64'(bus.done), 64'(0));

        // rotr by 1 on 81
        req(1'b1, 1, 0, 8'h81, 1'b0); cyc();
        req(1'b1, 5, 1, 8'h00, 1'b0); cyc();
        check("rotr_Q", 64'(bus.Q), 64'hC0);
        check("rotr_sout", 64'(bus.sout), 64'(1));
        check("rotr_busy", 64'(bus.busy), 64'(0));
        check("rotr_done", 64'(bus.done), 64'(1));
        req(1'b0, 0, 0, 8'h00, 1'b0); cyc();
        check("rotr_single_done", 64'(bus.done), 64'(0));

        // asr by 8 on 80
        req(1'b1, 1, 0, 8'h80, 1'b0); cyc();
        req(1'b1, 6, 8, 8'h00, 1'b0); cyc();
        req(1'b0, 0, 0, 8'h00, 1'b0);
        wait_done(20);
        check("asr_Q", 64'(bus.Q), 64'hFF);

        // shr by 0: Q unchanged, done pulses, never busy
        cyc();
        req(1'b1, 3, 0, 8'h00, 1'b0); cyc();
        check("amt0_Q", 64'(bus.Q), 64'hFF);
        check("amt0_done", 64'(bus.done), 64'(1));
        check("amt0_busy", 64'(bus.busy), 64'(0));

        // back-to-back: load issued during the done cycle of a shl by 2
        req(1'b1, 2, 2, 8'h00, 1'b0); cyc();
        req(1'b0, 0, 0, 8'h00, 1'b0); cyc();
        check("b2b_done", 64'(bus.done), 64'(1));
        check("b2b_shl_Q", 64'(bus.Q), 64'hFC);
        req(1'b1, 1, 0, 8'h3C, 1'b0); cyc();
        check("b2b_load_Q", 64'(bus.Q), 64'h3C);
        check("b2b_load_done", 64'(bus.done), 64'(1));

        // reset mid-shift aborts without a done pulse
        req(1'b1, 2, 5, 8'h00, 1'b1); cyc();
        req(1'b0, 0, 0, 8'h00, 1'b1); cyc();
        reset = 1'b1; cyc();
        check("abort_Q", 64'(bus.Q), 64'hA5);
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        reset = 1'b0; cyc();
        check("abort_no_done", 64'(bus.done), 64'(0));

        // randomized operations
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            req(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3)),
                W'($urandom), 1'($urandom_range(0, 1)));
            cyc();
        end
        reset = 1'b0;
        req(1'b0, 0, 0, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
